// File: rtl/mac_job_seq.sv
`timescale 1ns/1ps
// mac_job_seq: job sequencer for the shared MAC datapath.
//
// Accepts a dot-product job (mode, base address, length) while idle, issues
// one operand-buffer read per cycle, forwards the returned operand pairs to
// the MAC one cycle later, waits for the last product to accumulate, then
// captures the MAC accumulator. The result is held until the consumer takes
// it with res_valid/res_ready. abort returns to IDLE from any busy state.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   start / start_ready         job request / sequencer idle
//   cfg_mode, cfg_base, cfg_len job configuration, sampled on accept
//   abort                       cancel the running job
//   op_rd_en, op_rd_addr        operand buffer read strobe and address
//   op_rd_a, op_rd_b            operand data, valid one cycle after op_rd_en
//   mac_en, mac_float_int       MAC enable (low clears it) and mode (1:int)
//   mac_data_en, mac_data_a/b   MAC operand valid and operands
//   mac_over, mac_out           MAC done flag and accumulator
//   res_valid/res_ready         result handshake
//   res_data, res_err           captured accumulator, mac_over was low
//   perf_cycles                 job cycle counter (optional)
//
// Build option: define MAC_JOB_SEQ_PERF_EN to count cycles from accept
// through the capture cycle on perf_cycles; otherwise perf_cycles is 0.
module mac_job_seq #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              start_ready,
  input  logic              cfg_mode,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              abort,
  output logic              op_rd_en,
  output logic [ADDR_W-1:0] op_rd_addr,
  input  logic [15:0]       op_rd_a,
  input  logic [15:0]       op_rd_b,
  output logic              mac_en,
  output logic              mac_float_int,
  output logic              mac_data_en,
  output logic [15:0]       mac_data_a,
  output logic [15:0]       mac_data_b,
  input  logic              mac_over,
  input  logic [31:0]       mac_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [31:0]       res_data,
  output logic              res_err,
  output logic [15:0]       perf_cycles
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_CAPT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic               mode_r;
  logic [ADDR_W-1:0]  addr_r;
  logic [LEN_W-1:0]   len_r;
  logic [LEN_W-1:0]   idx_r;
  logic               data_en_r;
  logic [31:0]        res_data_r;
  logic               res_err_r;
  logic               accept_s;
  logic               last_idx_s;

  // abort has priority over start, so a simultaneous pair is not accepted
  assign accept_s   = (state_r == S_IDLE) && start && !abort;
  assign last_idx_s = (idx_r == (len_r - LEN_W'(1'b1)));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          if (cfg_len == '0) begin
            state_nxt_s = S_DONE;
          end else begin
            state_nxt_s = S_RUN;
          end
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_nxt_s = S_IDLE;
        end else if (last_idx_s) begin
          state_nxt_s = S_DRAIN;
        end else begin
          state_nxt_s = S_RUN;
        end
      end
      S_DRAIN: begin
        if (abort) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_CAPT;
        end
      end
      S_CAPT: begin
        if (abort) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_DONE;
        end
      end
      S_DONE: begin
        if (abort || res_ready) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_DONE;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // State-decoded control outputs
  always_comb begin
    start_ready = 1'b0;
    mac_en      = 1'b0;
    op_rd_en    = 1'b0;
    res_valid   = 1'b0;
    case (state_r)
      S_IDLE:  start_ready = 1'b1;
      S_RUN: begin
        mac_en   = 1'b1;
        op_rd_en = 1'b1;
      end
      S_DRAIN: mac_en    = 1'b1;
      S_CAPT:  mac_en    = 1'b1;
      S_DONE:  res_valid = 1'b1;
      default: begin
        start_ready = 1'b0;
      end
    endcase
  end

  // Job configuration, read address/index, operand valid and result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_r     <= 1'b0;
      addr_r     <= '0;
      len_r      <= '0;
      idx_r      <= '0;
      data_en_r  <= 1'b0;
      res_data_r <= 32'd0;
      res_err_r  <= 1'b0;
    end else begin
      // A read issued in an aborting RUN cycle is never forwarded
      data_en_r <= (state_r == S_RUN) && !abort;
      if (accept_s) begin
        mode_r <= cfg_mode;
        addr_r <= cfg_base;
        len_r  <= cfg_len;
        idx_r  <= '0;
        if (cfg_len == '0) begin
          res_data_r <= 32'd0;
          res_err_r  <= 1'b0;
        end
      end else if (state_r == S_RUN) begin
        // Address register wraps naturally modulo 2^ADDR_W
        addr_r <= addr_r + ADDR_W'(1'b1);
        idx_r  <= idx_r + LEN_W'(1'b1);
      end else if ((state_r == S_CAPT) && !abort) begin
        res_data_r <= mac_out;
        res_err_r  <= ~mac_over;
      end
    end
  end

  assign op_rd_addr    = addr_r;
  assign mac_float_int = mode_r;
  assign mac_data_en   = data_en_r;
  assign mac_data_a    = data_en_r ? op_rd_a : 16'd0;
  assign mac_data_b    = data_en_r ? op_rd_b : 16'd0;
  assign res_data      = res_data_r;
  assign res_err       = res_err_r;

`ifdef MAC_JOB_SEQ_PERF_EN
  logic [15:0] perf_r;

  // Busy-cycle counter: cleared on accept, counts RUN/DRAIN/CAPT, saturates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_r <= 16'd0;
    end else if (accept_s) begin
      perf_r <= 16'd0;
    end else if (((state_r == S_RUN) || (state_r == S_DRAIN) || (state_r == S_CAPT))
                 && (perf_r != 16'hFFFF)) begin
      perf_r <= perf_r + 16'd1;
    end
  end

  assign perf_cycles = perf_r;
`else
  assign perf_cycles = 16'd0;
`endif

endmodule

// File: doc/mac_job_seq.md
Name: mac_job_seq

Overview:
- Job sequencer for the shared MAC datapath.
- Accepts a dot-product job (mode, base address, length), streams operand pairs from the operand buffer into the MAC one per cycle, then captures the accumulated result.
- Holds the result until the consumer takes it.
- Sits between the host/control FSM and the MAC instance; it is the only driver of the MAC's enable, mode and data inputs.

Parameters:
- ADDR_W, 8, operand buffer address width
- LEN_W, 8, job length width (0..2^LEN_W-1 elements)

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous reset, active-high
- start  input  1  job request; accepted when start_ready=1
- start_ready  output  1  high only in IDLE
- cfg_mode  input  1  1:integer, 0:float; sampled on accept
- cfg_base  input  ADDR_W  first operand address; sampled on accept
- cfg_len  input  LEN_W  element count; sampled on accept
- abort  input  1  cancel current job
- op_rd_en  output  1  operand buffer read strobe
- op_rd_addr  output  ADDR_W  operand buffer read address
- op_rd_a  input  16  operand A, valid 1 cycle after op_rd_en
- op_rd_b  input  16  operand B, valid 1 cycle after op_rd_en
- mac_en  output  1  MAC enable; low clears MAC accumulator
- mac_float_int  output  1  MAC mode, = latched cfg_mode
- mac_data_en  output  1  MAC data valid
- mac_data_a  output  16  MAC operand A
- mac_data_b  output  16  MAC operand B
- mac_over  input  1  MAC done flag
- mac_out  input  32  MAC accumulator
- res_valid  output  1  result available
- res_ready  input  1  consumer accepts result
- res_data  output  32  captured accumulator
- res_err  output  1  mac_over was 0 at capture
- perf_cycles  output  16  see Optional Feature

Behaviour:
- Reset (async, any state): IDLE. All outputs 0 except start_ready=1. Latched config cleared.
- States: IDLE, RUN, DRAIN, CAPT, DONE.
- IDLE:
  - mac_en=0, so the MAC accumulator is held at 0.
  - start=1 at cycle T accepts the job: latch mode/base/len, load index=0.
  - len!=0: go to RUN at T+1.
  - len=0: go to DONE at T+1 with res_data=0, res_err=0. No reads issued; mac_en never asserted.
- RUN (cycles T+1..T+len):
  - mac_en=1.
  - op_rd_en=1, op_rd_addr=base+index (wraps modulo 2^ADDR_W), index increments each cycle.
  - After issuing index len-1, go to DRAIN.
- Data pipeline:
  - mac_data_en is op_rd_en delayed one cycle (registered valid).
  - mac_data_a/b are driven combinationally from op_rd_a/b, and are 0 when mac_data_en=0.
  - Operands therefore reach the MAC on cycles T+2..T+len+1; one product accumulates per edge.
- DRAIN (T+len+1):
  - mac_en=1, op_rd_en=0, last mac_data_en=1.
  - Go to CAPT.
- CAPT (T+len+2):
  - mac_en=1, mac_data_en=0; mac_out is now final.
  - On the edge: res_data<=mac_out, res_err<=~mac_over.
  - Go to DONE.
- DONE (from T+len+3):
  - res_valid=1, mac_en=0 (MAC clears).
  - res_data stable until res_valid&res_ready, then IDLE next cycle.
  - res_valid deasserts in the same edge as the handshake.
- Latency: accept to res_valid = len+3 cycles (1 cycle for len=0).
- abort=1 in RUN/DRAIN/CAPT/DONE:
  - Next state IDLE, with mac_en=0, op_rd_en=0, mac_data_en=0, res_valid=0.
  - Any in-flight read data is discarded.
- abort in IDLE: ignored. abort together with start in IDLE: start is not accepted.
- start while not IDLE: ignored; start_ready=0.
- mac_float_int is constant for the whole job, including DONE.
- cfg_* changes after accept have no effect on the running job.

Optional Feature:
- Macro: MAC_JOB_SEQ_PERF_EN.
- Defined:
  - perf_cycles counts cycles from accept (T+1 = 1) through the CAPT cycle, inclusive, saturating at 0xFFFF.
  - Cleared on accept, held in DONE and IDLE.
  - Expected value is len+2 (0 for len=0).
- Undefined: perf_cycles tied to 0 and no counter logic is instantiated.

Test Plan:
- Int job: base=0x10, len=3, A=[2,3,4], B=[5,6,7], ideal MAC model -> reads at 0x10..0x12 on T+1..T+3; res_valid at T+6; res_data=0x00000038; perf_cycles=5 with macro.
- Float job: mode=0, len=2, A=[0x3C00,0x4000], B=[0x4000,0x4000] -> mac_float_int=0 throughout; res_data=0x40C00000 (6.0).
- len=0 -> no op_rd_en and no mac_en pulse; res_valid at T+1; res_data=0.
- Address wrap: base=0xFE, len=4 -> op_rd_addr sequence 0xFE,0xFF,0x00,0x01.
- Backpressure: res_ready=0 for 5 cycles in DONE -> res_valid and res_data stable, start_ready=0, start ignored. Then res_ready=1 -> IDLE and a new start is accepted.
- Abort in RUN at index 1 of len=4 -> next cycle IDLE with mac_en=0 and no res_valid. Async rst mid-job -> all outputs reset immediately.
